// File: rtl/scaler_pkg.sv
`default_nettype none
// ==========================================================================
// Module   : scaler_pkg
// Purpose  : Shared constants and FSM state type for the horizontal step controller.
// Revision : 1.0
// ==========================================================================
package scaler_pkg;

  localparam int PIXEL_STEP_LOG2   = 12;
  localparam int DEF_PIXEL_STEP    = 1 << PIXEL_STEP_LOG2;
  localparam int DEF_WIDTH_W       = 12;
  localparam int DEF_STEP_WIDTH    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_PEND = 2'd2
  } h_state_e;

endpackage
`default_nettype wire

// File: rtl/scaler_div_serial.sv
`default_nettype none
// ==========================================================================
// Module   : scaler_div_serial
// Purpose  : Restoring bit-serial divider, one quotient bit per cycle.
// Revision : 1.0
// ==========================================================================
module scaler_div_serial #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem_q,  rem_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  dsor_q, dsor_d;
  logic [CNT_W-1:0]      cnt_q,  cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DIVISOR_W-1:0]  src_rem;
  logic [DIVIDEND_W-1:0] src_quot;
  logic [DIVISOR_W-1:0]  src_dsor;
  logic [DIVISOR_W:0]    shifted;
  logic                  ge;
  logic [DIVISOR_W-1:0]  step_rem;
  logic [DIVIDEND_W-1:0] step_quot;

  always_comb begin
    rem_d    = rem_q;
    quot_d   = quot_q;
    dsor_d   = dsor_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    src_rem  = rem_q;
    src_quot = quot_q;
    src_dsor = dsor_q;
    // The first quotient bit is resolved on the start edge itself.
    if (start) begin
      src_rem  = '0;
      src_quot = dividend;
      src_dsor = divisor;
    end
    shifted   = {src_rem, src_quot[DIVIDEND_W-1]};
    ge        = (shifted >= {1'b0, src_dsor});
    step_rem  = ge ? DIVISOR_W'(shifted - {1'b0, src_dsor}) : shifted[DIVISOR_W-1:0];
    step_quot = {src_quot[DIVIDEND_W-2:0], ge};

    if (start) begin
      rem_d  = step_rem;
      quot_d = step_quot;
      dsor_d = divisor;
      cnt_d  = CNT_W'(DIVIDEND_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = step_rem;
      quot_d = step_quot;
      cnt_d  = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsor_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dsor_q <= dsor_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quot_q;

endmodule
`default_nettype wire

// File: rtl/scaler_h_step_ctrl.sv
`default_nettype none
// ==========================================================================
// Module   : scaler_h_step_ctrl
// Purpose  : Computes the horizontal scale step and applies it at frame start.
//            Optional line-width meter: SCALER_H_AUTO_WIDTH_EN.
// Revision : 1.0
// ==========================================================================
module scaler_h_step_ctrl
  import scaler_pkg::*;
#(
  parameter int PIXEL_STEP = DEF_PIXEL_STEP,
  parameter int WIDTH_W    = DEF_WIDTH_W,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_W-1:0]    cfg_in_width,
  input  logic [WIDTH_W-1:0]    cfg_out_width,
  input  logic                  cfg_wr,
  output logic                  cfg_busy,
  output logic                  cfg_err,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [STEP_WIDTH-1:0] h_scale_step,
  output logic                  step_pending,
  output logic                  step_applied
`ifdef SCALER_H_AUTO_WIDTH_EN
  ,
  output logic [WIDTH_W-1:0]    meas_width
`endif
);

  localparam int STEP_LOG2 = $clog2(PIXEL_STEP);
  localparam int DIV_W     = WIDTH_W + STEP_LOG2;

  logic                  fs;
  logic [WIDTH_W-1:0]    eff_in;
  logic                  req_ok;
  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic [DIV_W-1:0]      div_quot;
  logic [STEP_WIDTH-1:0] pend_step;

  h_state_e              state_q, state_d;
  logic [STEP_WIDTH-1:0] h_step_q, h_step_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  pending_q, pending_d;
  logic                  applied_q, applied_d;

  assign fs = de_i & vs_i & hs_i;

`ifdef SCALER_H_AUTO_WIDTH_EN
  logic [WIDTH_W-1:0] line_cnt_q, line_cnt_d;
  logic               line_act_q, line_act_d;
  logic [WIDTH_W-1:0] meas_q, meas_d;

  // Count runs from one qualified line start up to (not including) the next.
  always_comb begin
    line_cnt_d = line_cnt_q;
    line_act_d = line_act_q;
    meas_d     = meas_q;
    if (de_i) begin
      if (hs_i) begin
        if (line_act_q) meas_d = line_cnt_q;
        line_act_d = 1'b1;
        line_cnt_d = WIDTH_W'(1);
      end else if (line_act_q && (line_cnt_q != '1)) begin
        line_cnt_d = line_cnt_q + WIDTH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cnt_q <= '0;
      line_act_q <= 1'b0;
      meas_q     <= '0;
    end else begin
      line_cnt_q <= line_cnt_d;
      line_act_q <= line_act_d;
      meas_q     <= meas_d;
    end
  end

  assign meas_width = meas_q;
  assign eff_in     = (cfg_in_width == '0) ? meas_q : cfg_in_width;
`else
  assign eff_in     = cfg_in_width;
`endif

  assign req_ok = (eff_in != '0) && (cfg_out_width != '0) && !div_busy;

  scaler_div_serial #(
    .DIVIDEND_W (DIV_W),
    .DIVISOR_W  (WIDTH_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({eff_in, {STEP_LOG2{1'b0}}}),
    .divisor  (cfg_out_width),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  generate
    if (DIV_W > STEP_WIDTH) begin : g_sat
      assign pend_step = (|div_quot[DIV_W-1:STEP_WIDTH]) ? '1 : div_quot[STEP_WIDTH-1:0];
    end else begin : g_nosat
      assign pend_step = STEP_WIDTH'(div_quot);
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    h_step_d  = h_step_q;
    err_d     = err_q;
    applied_d = 1'b0;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_PEND: begin
        // A new request always supersedes an unapplied result.
        if (cfg_wr) begin
          if (req_ok) begin
            div_start = 1'b1;
            err_d     = 1'b0;
            state_d   = ST_DIV;
          end else begin
            err_d     = 1'b1;
            state_d   = ST_IDLE;
          end
        end else if ((state_q == ST_PEND) && fs) begin
          h_step_d  = pend_step;
          applied_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_PEND;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d    = (state_d == ST_DIV);
    pending_d = (state_d == ST_PEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      h_step_q  <= STEP_WIDTH'(PIXEL_STEP);
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
      applied_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_step_q  <= h_step_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      pending_q <= pending_d;
      applied_q <= applied_d;
    end
  end

  assign h_scale_step = h_step_q;
  assign cfg_busy     = busy_q;
  assign cfg_err      = err_q;
  assign step_pending = pending_q;
  assign step_applied = applied_q;

endmodule
`default_nettype wire
